// File: rtl/seq_comp.sv
// seq_comp: multi-cycle magnitude comparator for the integer ALU path.
//
// The operands are compared CHUNK bits per cycle, starting with the most
// significant chunk. The compare stops at the first chunk that differs.
// Signed and unsigned compares are selected per operation, and six
// relational ops are supported.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operands and op are valid
//   in_ready   block can accept an operation (IDLE only)
//   a, b       WIDTH-bit operands
//   inst       op: 100 eq, 101 lt, 110 gt, 000 ne, 001 ge, 010 le
//   sgn        1 = two's-complement compare, 0 = unsigned
//   out_valid  result is valid (DONE)
//   out_ready  consumer accepts the result
//   s          compare result
//   err        inst was illegal (011 or 111); valid with out_valid
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_valid; operands are captured on acceptance
// CMP   | examining chunk idx; one chunk per cycle, MSB chunk first
// DONE  | s/err held; waiting for out_ready
module seq_comp #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       inst,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic             err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } rel_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       inst_q, inst_d;
  logic             sgn_q, sgn_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             s_q, s_d;
  logic             err_q, err_d;

  logic [CHUNK-1:0] msb_mask;
  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] ca, cb;
  rel_t             rel;
  logic             finish;
  logic             illegal;
  logic             res;

  always_comb begin
    msb_mask = '0;
    msb_mask[CHUNK-1] = 1'b1;
  end

  // Select the current chunk with constant indices only.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Inverting the sign bit of the top chunk in both operands maps
  // two's-complement ordering onto unsigned ordering.
  assign flip = (sgn_q && (idx_q == IDX_TOP)) ? msb_mask : '0;

  always_comb begin
    rel    = REL_EQ;
    finish = 1'b0;
    if ((ca ^ flip) != (cb ^ flip)) begin
      rel    = ((ca ^ flip) > (cb ^ flip)) ? REL_GT : REL_LT;
      finish = 1'b1;
    end else if (idx_q == '0) begin
      rel    = REL_EQ;
      finish = 1'b1;
    end
  end

  assign illegal = (inst_q[1:0] == 2'b11);

  always_comb begin
    res = 1'b0;
    case (inst_q)
      3'b100:  res = (rel == REL_EQ);
      3'b000:  res = (rel != REL_EQ);
      3'b101:  res = (rel == REL_LT);
      3'b110:  res = (rel == REL_GT);
      3'b010:  res = (rel != REL_GT);
      3'b001:  res = (rel != REL_LT);
      default: res = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    inst_d  = inst_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    s_d     = s_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          inst_d  = inst;
          sgn_d   = sgn;
          idx_d   = IDX_TOP;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (finish) begin
          s_d     = res;
          err_d   = illegal;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      inst_q  <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      s_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      inst_q  <= inst_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign s         = s_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_comp.sv
module tb_seq_comp;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       inst;
  logic             sgn;
  logic             out_valid;
  logic             out_ready;
  logic             s;
  logic             err;

  int passed = 0;
  int total  = 0;

  seq_comp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .inst      (inst),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Issue one op, scramble the inputs while it runs, measure latency,
  // hold the result for 'hold' cycles of backpressure, then retire it.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic [2:0] iv,
                        input logic sv, input int exp_k, input int exp_s,
                        input int exp_err, input int hold);
    int k;
    chk({tag, ".in_ready_idle"}, int'(in_ready), 1);
    a = av; b = bv; inst = iv; sgn = sv; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = ~av; b = av ^ 32'h5A5A_A5A5; inst = ~iv; sgn = ~sv;
    k = -1;
    for (int c = 1; c <= NCHUNK + 2; c++) begin
      tick();
      if (out_valid) begin
        k = c;
        break;
      end
    end
    chk({tag, ".latency"}, k, exp_k);
    chk({tag, ".s"}, int'(s), exp_s);
    chk({tag, ".err"}, int'(err), exp_err);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, ".hold_valid"}, int'(out_valid), 1);
      chk({tag, ".hold_s"}, int'(s), exp_s);
      chk({tag, ".hold_err"}, int'(err), exp_err);
      chk({tag, ".hold_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".retire_valid"}, int'(out_valid), 0);
    chk({tag, ".retire_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; inst = 3'b000; sgn = 1'b0;
    tick();
    tick();
    chk("rst.in_ready", int'(in_ready), 1);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.s", int'(s), 0);
    chk("rst.err", int'(err), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle.out_valid", int'(out_valid), 0);
      chk("idle.in_ready", int'(in_ready), 1);
    end

    // Top chunk differs: 0x80 vs 0x7F.
    run_op("early_gt_u", 32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 1'b0, 1, 1, 0, 0);
    run_op("early_gt_s", 32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 1'b1, 1, 0, 0, 0);
    run_op("early_lt_s", 32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b1, 1, 1, 0, 0);

    // Equal operands run the full length.
    run_op("eq_eq", 32'h1234_5678, 32'h1234_5678, 3'b100, 1'b0, 4, 1, 0, 0);
    run_op("eq_ne", 32'h1234_5678, 32'h1234_5678, 3'b000, 1'b0, 4, 0, 0, 0);
    run_op("eq_ge", 32'h1234_5678, 32'h1234_5678, 3'b001, 1'b0, 4, 1, 0, 0);

    // -2 vs -1: only the lowest chunk differs.
    run_op("low_lt", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b101, 1'b1, 4, 1, 0, 0);
    run_op("low_le", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b010, 1'b1, 4, 1, 0, 0);
    run_op("low_gt", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b110, 1'b1, 4, 0, 0, 0);

    // Chunk index 2 differs.
    run_op("mid_lt", 32'h0001_0000, 32'h0002_0000, 3'b101, 1'b0, 2, 1, 0, 0);
    run_op("mid_ge", 32'h0001_0000, 32'h0002_0000, 3'b001, 1'b0, 2, 0, 0, 0);

    // Illegal op with six cycles of backpressure, then a legal op clears err.
    run_op("illegal", 32'h0000_0005, 32'h0000_0003, 3'b011, 1'b0, 4, 0, 1, 6);
    run_op("illegal7", 32'h8000_0000, 32'h0000_0000, 3'b111, 1'b1, 1, 0, 1, 0);
    run_op("after_ill", 32'h0000_0005, 32'h0000_0003, 3'b110, 1'b0, 4, 1, 0, 0);

    // Reset while comparing: no result may follow.
    a = 32'd1; b = 32'd2; inst = 3'b101; sgn = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_cmp.in_ready", int'(in_ready), 1);
    chk("rst_cmp.out_valid", int'(out_valid), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_cmp.no_pulse", int'(out_valid), 0);
    end

    // Reset while a result is pending drops it.
    a = 32'h8000_0000; b = 32'h0; inst = 3'b110; sgn = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rst_done.valid_before", int'(out_valid), 1);
    chk("rst_done.s_before", int'(s), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_done.out_valid", int'(out_valid), 0);
    chk("rst_done.s", int'(s), 0);
    chk("rst_done.in_ready", int'(in_ready), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_comp.md
Name: seq_comp

Overview:
- Parametrised, multi-cycle successor to the integer unsigned/signed comparators.
- Compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB chunk, and stops at the first chunk that differs.
- Signed and unsigned modes are selected at run time; six relational ops are supported.
- Sits in the integer ALU path behind a valid/ready handshake, so wide operands do not need a single-cycle full-width compare.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of compare steps.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- inst  input  3  op select: 100 eq, 101 lt, 110 gt, 000 ne, 001 ge, 010 le.
- sgn  input  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- s  output  1  compare result.
- err  output  1  inst was illegal (011 or 111); valid with out_valid.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; in_ready=1; out_valid=0; s=0; err=0; chunk index cleared.
  - Reset aborts any in-flight op and discards any pending result.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture a, b, inst, sgn; set idx=NCHUNK-1; go to CMP.
- CMP:
  - in_ready=0; in_valid is ignored.
  - Each edge examines chunk idx, i.e. bits [idx*CHUNK+CHUNK-1 : idx*CHUNK].
  - Signed mode: the top chunk is compared with its MSB inverted in both operands, which makes unsigned chunk ordering equal signed ordering. Lower chunks are always compared unsigned.
  - If the chunks differ: record gt or lt for that chunk, compute s, go to DONE.
  - If they are equal and idx==0: record eq, compute s, go to DONE.
  - Otherwise: idx decrements; stay in CMP.
- Result mapping (from the recorded relation rel):
  - eq: s = (rel==eq)
  - ne: s = (rel!=eq)
  - lt: s = (rel==lt)
  - gt: s = (rel==gt)
  - le: s = (rel!=gt)
  - ge: s = (rel!=lt)
- Illegal inst: the compare still runs its normal length; s=0, err=1.
- DONE:
  - out_valid=1; s and err are held stable.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - No new operation is accepted in the same cycle as result retirement (in_ready=0 in DONE).
- Latency:
  - Accept at edge E0; out_valid rises after edge Ek.
  - k = (NCHUNK - index of first differing chunk), in the range 1..NCHUNK.
  - Equal operands give k=NCHUNK.
  - With CHUNK=WIDTH, k=1 always.
- Throughput: one op per k+2 cycles minimum (IDLE, k cycles of CMP, DONE).
- Boundary conditions:
  - out_ready held low: result is held indefinitely with no loss.
  - Input changes during CMP or DONE have no effect, because operands are registered.
  - rst during DONE drops out_valid on the next edge.
- s and err are registered and change only when entering DONE or on reset.

Test Plan:
- Reset: rst=1 for 2 cycles -> in_ready=1, out_valid=0, s=0, err=0; release, hold in_valid=0 for 5 cycles -> no output activity.
- Early exit: WIDTH=32, CHUNK=8, a=0x80000000, b=0x7FFFFFFF, sgn=0, inst=110 -> out_valid after 1 cycle, s=1. Same operands with sgn=1 -> s=0 after 1 cycle.
- Full-length equal: a=b=0x12345678.
  - inst=100 -> s=1, out_valid exactly 4 cycles after accept.
  - inst=000 -> s=0.
  - inst=001 -> s=1.
- Low-chunk difference:
  - a=0xFFFFFFFE, b=0xFFFFFFFF, sgn=1, inst=101 -> s=1 (-2 < -1) after 4 cycles.
  - inst=010 -> s=1.
  - inst=110 -> s=0.
- Backpressure and illegal op: inst=011, out_ready=0 for 6 cycles -> out_valid stays high, s=0, err=1, in_ready=0 throughout. Assert out_ready -> out_valid drops and in_ready rises on the next edge.
- Reset mid-op: accept a=1, b=2 (4-cycle compare), assert rst in cycle 2 -> in_ready=1 next edge, and no out_valid pulse follows.
